// File: rtl/vend_mech_responder.sv
// Mechanism-side responder: runs motor/coin actuation per request, confirms drops, tracks stock and vends.
// Latency: a request edge seen in IDLE drives outputs two clocks later; no backpressure, requests queue as pending flags.
module vend_mech_responder #(
  parameter int MOTOR_MAX  = 20,
  parameter int SETTLE_CYC = 3,
  parameter int COIN_PULSE = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dispense_item,
  input  logic               return_coin,
  input  logic               drop_sensor,
  input  logic               fault_clr,
  input  logic               restock,
  output logic               motor_on,
  output logic               coin_release,
  output logic               busy,
  output logic               done,
  output logic               sold_out,
  output logic               fault,
  output logic [STOCK_W-1:0] stock,
  output logic [CNT_W-1:0]   vend_count
);

  localparam int TMAX_A = (MOTOR_MAX > SETTLE_CYC) ? MOTOR_MAX : SETTLE_CYC;
  localparam int TMAX   = (TMAX_A > COIN_PULSE) ? TMAX_A : COIN_PULSE;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOTOR  = 3'd1,
    SETTLE = 3'd2,
    COIN   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t        state;
  logic          disp_q;
  logic          ret_q;
  logic          pend_disp;
  logic          pend_ret;
  logic [TW-1:0] timer;
  logic          disp_edge;
  logic          ret_edge;

  assign disp_edge = dispense_item & ~disp_q;
  assign ret_edge  = return_coin & ~ret_q;
  assign busy      = (state != IDLE);
  assign sold_out  = (stock == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      disp_q       <= 1'b0;
      ret_q        <= 1'b0;
      pend_disp    <= 1'b0;
      pend_ret     <= 1'b0;
      timer        <= '0;
      motor_on     <= 1'b0;
      coin_release <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      stock        <= STOCK_W'(STOCK_INIT);
      vend_count   <= '0;
    end else begin
      disp_q <= dispense_item;
      ret_q  <= return_coin;
      done   <= 1'b0;

      // A flag already set absorbs a repeated edge; the service clear below overrides both.
      if (disp_edge) pend_disp <= 1'b1;
      if (ret_edge)  pend_ret  <= 1'b1;

      case (state)
        IDLE: begin
          if (pend_disp) begin
            pend_disp <= 1'b0;
            timer     <= TW'(1);
            if (stock != '0) begin
              state    <= MOTOR;
              motor_on <= 1'b1;
            end else begin
              state        <= COIN;
              coin_release <= 1'b1;
            end
          end else if (pend_ret) begin
            pend_ret     <= 1'b0;
            timer        <= TW'(1);
            state        <= COIN;
            coin_release <= 1'b1;
          end
        end

        MOTOR: begin
          if (drop_sensor) begin
            state      <= SETTLE;
            motor_on   <= 1'b0;
            timer      <= TW'(1);
            vend_count <= vend_count + 1'b1;
            if (stock != '0) stock <= stock - 1'b1;
          end else if (timer == TW'(MOTOR_MAX)) begin
            state    <= FAULT;
            motor_on <= 1'b0;
            fault    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SETTLE: begin
          if (timer == TW'(SETTLE_CYC)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        COIN: begin
          if (timer == TW'(COIN_PULSE)) begin
            state        <= IDLE;
            coin_release <= 1'b0;
            done         <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FAULT: begin
          // Clearing a jam refunds the customer rather than retrying the vend.
          if (fault_clr) begin
            state        <= COIN;
            fault        <= 1'b0;
            coin_release <= 1'b1;
            timer        <= TW'(1);
          end
        end

        default: begin
          state        <= IDLE;
          motor_on     <= 1'b0;
          coin_release <= 1'b0;
          fault        <= 1'b0;
        end
      endcase

      if (restock) stock <= STOCK_W'(STOCK_INIT);
    end
  end

endmodule

// File: tb/tb_vend_mech_responder.sv
// Bench for vend_mech_responder: directed scenarios plus randomized operations against a transaction-level model.
module tb_vend_mech_responder;
  localparam int MOTOR_MAX  = 20;
  localparam int SETTLE_CYC = 3;
  localparam int COIN_PULSE = 4;
  localparam int STOCK_INIT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dispense_item = 1'b0;
  logic       return_coin = 1'b0;
  logic       drop_sensor = 1'b0;
  logic       fault_clr = 1'b0;
  logic       restock = 1'b0;
  logic       motor_on, coin_release, busy, done, sold_out, fault;
  logic [3:0] stock;
  logic [7:0] vend_count;

  int cmp_n = 0;
  int fail_n = 0;
  int stock_m = STOCK_INIT;
  int vc_m = 0;

  vend_mech_responder dut (
    .clk(clk), .reset(reset), .dispense_item(dispense_item), .return_coin(return_coin),
    .drop_sensor(drop_sensor), .fault_clr(fault_clr), .restock(restock),
    .motor_on(motor_on), .coin_release(coin_release), .busy(busy), .done(done),
    .sold_out(sold_out), .fault(fault), .stock(stock), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " stock"}, stock, stock_m);
    chk({tag, " vend_count"}, vend_count, vc_m);
    chk({tag, " sold_out"}, sold_out, (stock_m == 0));
  endtask

  task automatic idle_restock(input string tag);
    restock = 1'b1;
    tick;
    restock = 1'b0;
    stock_m = STOCK_INIT;
    chk_model(tag);
  endtask

  task automatic idle_noise(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drop_sensor = ($urandom_range(0, 1) == 1);
      fault_clr   = ($urandom_range(0, 1) == 1);
      tick;
      chk({tag, " idle busy"}, busy, 0);
    end
    drop_sensor = 1'b0;
    fault_clr   = 1'b0;
  endtask

  // One operation from idle: expected actuation counts follow from the stock model and the request mix.
  task automatic run_op(input bit disp, input bit ret, input int drop_at, input int fault_wait,
                        input bit dup, input bit rs_settle, input string tag);
    int mc = 0, cc = 0, sc = 0, fc = 0, dc = 0;
    int first_busy = 0, first_kind = 0, excl_bad = 0;
    int exp_m = 0, exp_c = 0, exp_s = 0, exp_f = 0, exp_d = 0, exp_kind = 0;
    bit success = 0, rs_done = 0, rs_check = 0;

    if (disp) begin
      exp_d++;
      if (stock_m > 0) begin
        exp_kind = 1;
        if (drop_at > 0) begin
          exp_m = drop_at; exp_s = SETTLE_CYC; success = 1;
        end else begin
          exp_m = MOTOR_MAX; exp_f = fault_wait; exp_c += COIN_PULSE;
        end
      end else begin
        exp_kind = 2; exp_c += COIN_PULSE;
      end
    end
    if (ret) begin
      if (!disp) exp_kind = 2;
      exp_c += COIN_PULSE; exp_d++;
    end
    if (dup) begin
      exp_c += COIN_PULSE; exp_d++;
    end

    dispense_item = disp;
    return_coin   = ret;
    for (int it = 1; it <= 300 && dc < exp_d; it++) begin
      tick;
      if (motor_on) mc++;
      if (coin_release) cc++;
      if (fault) fc++;
      if (busy && !motor_on && !coin_release && !fault) sc++;
      if (done) dc++;
      if (motor_on && coin_release) excl_bad++;
      if (fault && (motor_on || coin_release)) excl_bad++;
      if (busy && first_busy == 0) first_busy = it;
      if (first_kind == 0) first_kind = motor_on ? 1 : (coin_release ? 2 : 0);
      if (rs_check) begin
        chk({tag, " restock stock"}, stock, STOCK_INIT);
        chk({tag, " restock sold_out"}, sold_out, 0);
        restock = 1'b0; rs_check = 0;
      end
      if (rs_settle && !rs_done && sc == 1) begin
        restock = 1'b1; rs_done = 1; rs_check = 1;
      end
      if (it == 1) begin dispense_item = 1'b0; return_coin = 1'b0; end
      if (dup && (it == 3 || it == 5)) return_coin = 1'b1;
      if (dup && (it == 4 || it == 6)) return_coin = 1'b0;
      drop_sensor = motor_on ? (mc == drop_at) : ($urandom_range(0, 3) == 0);
      fault_clr   = fault ? (fc == fault_wait) : ($urandom_range(0, 4) == 0);
    end
    dispense_item = 1'b0; return_coin = 1'b0; drop_sensor = 1'b0;
    fault_clr = 1'b0; restock = 1'b0;

    chk({tag, " done pulses"}, dc, exp_d);
    chk({tag, " motor cycles"}, mc, exp_m);
    chk({tag, " coin cycles"}, cc, exp_c);
    chk({tag, " settle cycles"}, sc, exp_s);
    chk({tag, " fault cycles"}, fc, exp_f);
    chk({tag, " start latency"}, first_busy, 2);
    chk({tag, " first actuator"}, first_kind, exp_kind);
    chk({tag, " exclusive outputs"}, excl_bad, 0);
    if (success) begin
      stock_m--;
      vc_m = (vc_m + 1) % 256;
      if (rs_settle) stock_m = STOCK_INIT;
    end
    chk_model(tag);
    tick;
    chk({tag, " done single"}, done, 0);
    chk({tag, " back idle"}, busy, 0);
  endtask

  initial begin
    int n_ops;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst motor_on", motor_on, 0);
    chk("rst coin_release", coin_release, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fault", fault, 0);
    chk_model("rst");
    reset = 1'b0;
    tick;

    // Basic vend with drop on the 5th motor cycle, then a jam with fault clear
    run_op(1, 0, 5, 1, 0, 0, "t1 vend");
    run_op(1, 0, 0, 3, 0, 0, "t2 jam");
    idle_noise(4, "noise");
    chk_model("after noise");

    // Drain stock, then a sold-out dispense refunds without motor
    idle_restock("t3 restock");
    for (int i = 0; i < 5; i++) run_op(1, 0, $urandom_range(1, MOTOR_MAX), 1, 0, 0, "t3 drain");
    chk("t3 sold_out", sold_out, 1);
    run_op(1, 0, 3, 1, 0, 0, "t3 soldout");

    // Simultaneous requests: vend before refund
    idle_restock("t4 restock");
    run_op(1, 1, $urandom_range(1, MOTOR_MAX), 1, 0, 0, "t4 both");
    run_op(0, 1, 0, 1, 1, 0, "t4 dup refund");

    // Restock while settling the last item
    for (int i = 0; i < 3; i++) run_op(1, 0, $urandom_range(1, MOTOR_MAX), 1, 0, 0, "t6 vend");
    chk("t6 stock one", stock, 1);
    run_op(1, 0, MOTOR_MAX, 1, 0, 1, "t6 last");

    // Reset in MOTOR; dispense held high across release counts as an edge
    dispense_item = 1'b1;
    tick;
    dispense_item = 1'b0;
    tick;
    chk("t5 motor running", motor_on, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("t5 motor_on", motor_on, 0);
    chk("t5 coin_release", coin_release, 0);
    chk("t5 busy", busy, 0);
    stock_m = STOCK_INIT;
    vc_m = 0;
    chk_model("t5");
    dispense_item = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    run_op(1, 0, $urandom_range(1, MOTOR_MAX), 1, 0, 0, "t5 held edge");

    // Randomized operations
    n_ops = 40;
    for (int k = 0; k < n_ops; k++) begin
      bit d, r, dp, rs;
      int da;
      d  = ($urandom_range(0, 2) != 0);
      r  = !d || ($urandom_range(0, 3) == 0);
      dp = !r && ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 9) == 0);
      da = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MOTOR_MAX);
      run_op(d, r, da, $urandom_range(1, 4), dp, rs, "rand");
      if ($urandom_range(0, 5) == 0) idle_restock("rand restock");
      idle_noise($urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
